mem_backend_model: RTL



---
 rtl/mem_backend_model.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_backend_model.sv
// Behavioural single-port word memory used as the endpoint behind memory_controller.
// Services read/write commands after a fixed per-direction latency, pulses
// response_complete once per transaction and waits for the command to drop.
module mem_backend_model #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 3,
    parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] request_command,
    input  logic [31:0] request_addr,
    input  logic [31:0] request_data,
    output logic        response_complete,
    output logic [31:0] response_data,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned IW = 30;
    localparam int unsigned CW = 8;

    localparam logic [31:0] CMD_NONE  = 32'd0;
    localparam logic [31:0] CMD_READ  = 32'd1;
    localparam logic [31:0] CMD_WRITE = 32'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_write_q;
    logic [AW-1:0]   idx_q;
    logic            oor_q;
    logic [31:0]     data_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [IW-1:0]   word_idx_c;
    logic            oor_c;
    logic            access_c;
    logic            unused_addr_lsb_c;

    // Word index decode; the byte offset bits carry no meaning here.
    assign word_idx_c        = request_addr[31:2];
    assign oor_c             = (word_idx_c >= IW'(DEPTH_WORDS));
    assign access_c          = (state == COUNT) && (cnt == CW'(0));
    assign unused_addr_lsb_c = ^request_addr[1:0];

    // Transaction FSM: capture in IDLE, count down, respond, then wait for command release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= CW'(0);
            is_write_q        <= 1'b0;
            idx_q             <= '0;
            oor_q             <= 1'b0;
            data_q            <= 32'd0;
            response_complete <= 1'b0;
            response_data     <= 32'd0;
            busy              <= 1'b0;
            err               <= 1'b0;
        end else begin
            response_complete <= 1'b0;
            err               <= 1'b0;
            case (state)
                IDLE: begin
                    if ((request_command == CMD_READ) || (request_command == CMD_WRITE)) begin
                        is_write_q <= (request_command == CMD_WRITE);
                        idx_q      <= word_idx_c[AW-1:0];
                        oor_q      <= oor_c;
                        data_q     <= request_data;
                        cnt        <= (request_command == CMD_WRITE) ? CW'(WRITE_LATENCY - 1)
                                                                     : CW'(READ_LATENCY - 1);
                        state      <= COUNT;
                        busy       <= 1'b1;
                    end else if (request_command != CMD_NONE) begin
                        // Illegal command: flag it and wait for release without responding.
                        err   <= 1'b1;
                        state <= RELEASE;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (cnt == CW'(0)) begin
                        state             <= RESP;
                        response_complete <= 1'b1;
                        err               <= oor_q;
                        if (!is_write_q) begin
                            response_data <= oor_q ? ERR_DATA : mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (request_command == CMD_NONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array write at the end of the countdown; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && access_c && is_write_q && !oor_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule
